// File: rtl/fifo_word_serializer.sv
// Pops IN_WIDTH-bit FIFO words and emits them as IN_WIDTH/OUT_WIDTH narrow valid/ready beats.
// Define SER_MSB_FIRST_EN to emit the most-significant slice of each word first.
module fifo_word_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [IN_WIDTH-1:0]   hold;
    logic [CNT_W-1:0]      cnt;
    logic [OUT_WIDTH-1:0]  slices [RATIO];

    // Beat k of the held word; out_data is a pure mux of registered state.
    for (genvar k = 0; k < RATIO; k++) begin : g_slice
`ifdef SER_MSB_FIRST_EN
        assign slices[k] = hold[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
`else
        assign slices[k] = hold[k*OUT_WIDTH +: OUT_WIDTH];
`endif
    end

    assign out_data  = slices[cnt];
    assign out_valid = (state == SHIFT);
    assign out_last  = (state == SHIFT) && (cnt == LAST_CNT);
    assign busy      = (state == SHIFT);
    assign in_ready  = (state == IDLE) || (out_last && out_ready);

    // A new word is loaded either from IDLE or on the accepted last beat, so
    // consecutive words stream without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold  <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (cnt != LAST_CNT) begin
                            cnt <= cnt + 1'b1;
                        end else if (in_valid) begin
                            hold <= in_data;
                            cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Read-side consumer for the team's FIFOs. Pops IN_WIDTH-bit words through the FIFO read handshake (valid/ready, first-word-fall-through data) and emits them as RATIO = IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready output stream.
- Sits in the read clock domain, between the async FIFO read port and a narrow lane/link datapath.
- Sustains one beat per cycle with no bubble between consecutive words.

Parameters:
- IN_WIDTH, 64, width of the popped FIFO word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, width of each output beat; RATIO = IN_WIDTH/OUT_WIDTH must be >= 2.
- CNT_W, $clog2(IN_WIDTH/OUT_WIDTH), beat counter width (derived localparam, not overridden).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  FIFO has a word (FIFO ~empty)
- in_ready  output  1  pop request to FIFO; a word transfers when in_valid & in_ready at the rising edge
- in_data  input  IN_WIDTH  FIFO head word, valid whenever in_valid=1
- out_valid  output  1  beat available
- out_ready  input  1  downstream accepts beat
- out_data  output  OUT_WIDTH  current beat
- out_last  output  1  high on the final beat of a word
- busy  output  1  high while a word is held (state SHIFT)

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, hold=0. Outputs: out_valid=0, out_last=0, busy=0, in_ready=1, out_data=0.
- Datapath: registered hold[IN_WIDTH-1:0] and cnt[CNT_W-1:0]. out_data = hold[cnt*OUT_WIDTH +: OUT_WIDTH] (mux of registered state only; no combinational path from in_data to out_data).
- States:
  - IDLE: out_valid=0, in_ready=1. On in_valid: hold<=in_data, cnt<=0, go to SHIFT.
  - SHIFT: out_valid=1. out_last=(cnt==RATIO-1).
    - On out_ready & ~out_last: cnt<=cnt+1.
    - On out_ready & out_last & in_valid: hold<=in_data, cnt<=0, stay in SHIFT (back-to-back, no bubble).
    - On out_ready & out_last & ~in_valid: go to IDLE.
- in_ready = (state==IDLE) | (state==SHIFT & out_last & out_ready). in_ready is combinational from out_ready; that path is permitted.
- Latency: a word popped at edge N produces its first beat with out_valid=1 in the cycle after N. A word takes RATIO beats; steady-state throughput is 1 beat/cycle.
- Output stability: while out_valid=1 & out_ready=0, out_data and out_last hold and cnt does not advance.
- Pop rule: never pop while a word is still being emitted. in_ready=0 in SHIFT except on the accepted last beat.
- Wrap: cnt wraps only via reload to 0; it never increments past RATIO-1.
- Simultaneous last-beat accept and new-word pop in one edge: the new word is loaded and its beat 0 is presented next cycle.
- Reset mid-word: the held word is discarded with no further beats. Words already popped are lost; the FIFO is reset by the same rst.
- busy = (state==SHIFT).

Optional Feature:
- Macro: SER_MSB_FIRST_EN.
- Defined: beat k outputs hold[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH], i.e. most-significant slice first.
- Undefined (default): least-significant slice first, as above.
- Handshake, latency and out_last timing are identical in both builds.

Test Plan:
- Single word, out_ready=1 always: push 64'h1111_2222_3333_4444 → beats 16'h4444, 3333, 2222, 1111 on 4 consecutive cycles; out_last only on 1111; in_ready=1 for 1 cycle at the pop, then 0 until the last beat; IDLE afterwards.
- Back-to-back: FIFO holds 64'hAAAA_BBBB_CCCC_DDDD then 64'h0001_0002_0003_0004, out_ready=1 → 8 beats on 8 consecutive cycles (DDDD, CCCC, BBBB, AAAA, 0004, 0003, 0002, 0001); out_valid never drops; second pop coincides with the AAAA accept.
- Backpressure: out_ready=0 for 3 cycles on beat 1 → out_data stays 16'h3333 and cnt frozen; resumes with 2222 after out_ready=1; no pop occurs during the stall.
- Reset mid-word: assert rst after beat 0x3333 is accepted → out_valid=0, busy=0, in_ready=1 immediately (async); after release, no remaining beats of that word appear.
- Empty FIFO: in_valid=0 for 10 cycles → out_valid=0, in_ready=1, state IDLE throughout.
- SER_MSB_FIRST_EN build: push 64'h1111_2222_3333_4444 → beats 1111, 2222, 3333, 4444; out_last on 4444.
